// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready result side.
// Latency: one cycle after accept for single-cycle ops. MUL, and DIV/REM when built, take
// WIDTH+1 cycles.
// Backpressure: in_ready only in IDLE. Results are held in DONE until out_ready.
// Optional feature: define ALU_SEQ_DIV_EN to build DIV/REM (restoring divider). Without it
// modes 9/10 are illegal.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, sel_mode (request);
//        out_valid/out_ready, result, result_hi, carry, zero, err (response).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] M_ADD = 4'd0, M_SUB = 4'd1, M_AND = 4'd2, M_OR  = 4'd3,
                         M_XOR = 4'd4, M_SLL = 4'd5, M_SRL = 4'd6, M_MUL = 4'd7,
                         M_SRA = 4'd8;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] M_DIV = 4'd9, M_REM = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  logic               accept, last;
  logic [CW-1:0]      cnt, sh;
  logic [WIDTH-1:0]   op_r;          // multiplicand (MUL) or divisor (DIV/REM)
  logic [2*WIDTH-1:0] prod, step;    // {hi, lo} working register of the iterative unit
  logic [WIDTH:0]     mul_sum, sum_ext;
  logic [WIDTH-1:0]   res_q, hi_q, sc_res;
  logic               carry_q, err_q, sc_carry, sc_err, is_multi;
`ifdef ALU_SEQ_DIV_EN
  logic               div_sel;
  logic [3:0]         mode_r;
  logic [WIDTH:0]     rem_sh, diff;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(WIDTH - 1));

  // Single-cycle datapath, evaluated straight from the request inputs.
  always_comb begin
    sh       = b[CW-1:0];
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    is_multi = 1'b0;
    sum_ext  = '0;
`ifdef ALU_SEQ_DIV_EN
    div_sel  = 1'b0;
`endif
    case (sel_mode)
      M_ADD: begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
      end
      M_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b).
        sum_ext  = {1'b0, a} - {1'b0, b};
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
      end
      M_AND: sc_res = a & b;
      M_OR:  sc_res = a | b;
      M_XOR: sc_res = a ^ b;
      M_SLL: sc_res = a << sh;
      M_SRL: sc_res = a >> sh;
      M_SRA: sc_res = $unsigned($signed(a) >>> sh);
      M_MUL: is_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      M_DIV, M_REM: begin
        is_multi = 1'b1;
        div_sel  = 1'b1;
        sc_err   = (b == '0);
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration of the multi-cycle unit.
  always_comb begin
    // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, op_r} : '0);
    step    = {mul_sum, prod[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Restoring division: the upper half is the partial remainder, the lower half shifts
    // the dividend out and the quotient in. A zero divisor always succeeds, which gives
    // an all-ones quotient and remainder = a without special casing.
    rem_sh = prod[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, op_r};
    if (mode_r != M_MUL) begin
      if (diff[WIDTH]) step = {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else             step = {diff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = is_multi ? BUSY : DONE;
      end
      BUSY: if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_r    <= '0;
      prod    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      mode_r  <= '0;
`endif
    end else if (accept) begin
      cnt     <= '0;
      res_q   <= sc_res;
      hi_q    <= '0;
      carry_q <= sc_carry;
      err_q   <= sc_err;
`ifdef ALU_SEQ_DIV_EN
      mode_r  <= sel_mode;
      op_r    <= div_sel ? b : a;
      prod    <= {{WIDTH{1'b0}}, (div_sel ? a : b)};
`else
      op_r    <= a;
      prod    <= {{WIDTH{1'b0}}, b};
`endif
    end else if (state == BUSY) begin
      cnt  <= cnt + CW'(1);
      prod <= step;
      if (last) begin
`ifdef ALU_SEQ_DIV_EN
        case (mode_r)
          M_MUL: begin
            res_q <= step[WIDTH-1:0];
            hi_q  <= step[2*WIDTH-1:WIDTH];
          end
          M_DIV:   res_q <= step[WIDTH-1:0];
          default: res_q <= step[2*WIDTH-1:WIDTH];
        endcase
`else
        res_q <= step[WIDTH-1:0];
        hi_q  <= step[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

  // All result outputs read as zero unless a result is being presented.
  assign result    = out_valid ? res_q : '0;
  assign result_hi = out_valid ? hi_q  : '0;
  assign carry     = out_valid && carry_q;
  assign err       = out_valid && err_q;
  assign zero      = out_valid && (res_q == '0);
endmodule
